// File: rtl/avalon_bram_arbiter.sv
// Two-host round-robin arbiter in front of one Avalon-MM BRAM agent.
// Define AVALON_ARB_TIMEOUT_EN to enable the read-response watchdog.
module avalon_bram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] h0_address,
    input  logic              h0_read,
    input  logic              h0_write,
    input  logic [DATA_W-1:0] h0_writedata,
    output logic [DATA_W-1:0] h0_readdata,
    output logic              h0_readdatavalid,
    output logic              h0_waitrequest,
    input  logic [ADDR_W-1:0] h1_address,
    input  logic              h1_read,
    input  logic              h1_write,
    input  logic [DATA_W-1:0] h1_writedata,
    output logic [DATA_W-1:0] h1_readdata,
    output logic              h1_readdatavalid,
    output logic              h1_waitrequest,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest,
    output logic              err_timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_RD} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

    logic              o_rd, o_wr;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wdata;
    logic              rsp;
    logic [DATA_W-1:0] rsp_data;
    logic              expire;
    logic [DATA_W-1:0] expire_data;

`ifdef AVALON_ARB_TIMEOUT_EN
    localparam int CLG   = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = (CLG > 8) ? CLG : 8;
    localparam logic [DATA_W-1:0] TO_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign expire = (state_q == WAIT_RD) && !m_readdatavalid
                 && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign expire_data = TO_DATA;
    assign err_timeout = err_q;

    // Counter is zero outside WAIT_RD, so it restarts on every entry.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (state_q == WAIT_RD) cnt_d = cnt_q + 1'b1;
        if (expire) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign expire      = 1'b0;
    assign expire_data = '0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        o_rd    = owner_q ? h1_read      : h0_read;
        o_wr    = owner_q ? h1_write     : h0_write;
        o_addr  = owner_q ? h1_address   : h0_address;
        o_wdata = owner_q ? h1_writedata : h0_writedata;
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd0_d          = rd0_q;
        rd1_d          = rd1_q;
        m_read         = 1'b0;
        m_write        = 1'b0;
        m_address      = addr_q;
        m_writedata    = wdata_q;
        h0_waitrequest = 1'b1;
        h1_waitrequest = 1'b1;
        rsp            = 1'b0;
        rsp_data       = m_readdata;
        unique case (state_q)
            IDLE: begin
                if (h0_read | h0_write | h1_read | h1_write) state_d = GRANT;
                if ((h0_read | h0_write) && (h1_read | h1_write))
                    owner_d = ~last_q;
                else if (h0_read | h0_write)
                    owner_d = 1'b0;
                else if (h1_read | h1_write)
                    owner_d = 1'b1;
            end
            GRANT: begin
                // Write wins when a host raises both strobes.
                m_write     = o_wr;
                m_read      = o_rd & ~o_wr;
                m_address   = o_addr;
                m_writedata = o_wdata;
                addr_d      = o_addr;
                wdata_d     = o_wdata;
                if (owner_q) h1_waitrequest = m_waitrequest;
                else         h0_waitrequest = m_waitrequest;
                if (!(o_rd | o_wr)) begin
                    state_d = IDLE;
                end else if (!m_waitrequest) begin
                    last_d  = owner_q;
                    state_d = o_wr ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (m_readdatavalid) begin
                    rsp = 1'b1;
                end else if (expire) begin
                    rsp      = 1'b1;
                    rsp_data = expire_data;
                end
                if (rsp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rsp && owner_q)  rd1_d = rsp_data;
        if (rsp && !owner_q) rd0_d = rsp_data;
    end

    assign h0_readdatavalid = rsp & ~owner_q;
    assign h1_readdatavalid = rsp & owner_q;
    assign h0_readdata      = rd0_d;
    assign h1_readdata      = rd1_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

endmodule
